// File: rtl/dec_sel_scan_sequencer.sv
// Select sequencer feeding a one-hot decoder: steps sel from 0 to a latched last
// index, holding each value for a latched dwell, in one-shot or wrapping mode.
module dec_sel_scan_sequencer #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               mode_cont_i,
   input  logic [SEL_W-1:0]   sel_last_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic [SEL_W-1:0]   sel_o,
   output logic               sel_valid_o,
   output logic               busy_o,
   output logic               step_o,
   output logic               wrap_o,
   output logic               done_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] reload_q, reload_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic               mode_q, mode_d;
   logic               step_q, step_d;
   logic               wrap_q, wrap_d;
   logic               done_q, done_d;
   logic [DWELL_W-1:0] reload_in;

   // The counter runs D-1 down to 0, so a zero dwell behaves exactly like one.
   assign reload_in = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         cnt_q    <= '0;
         reload_q <= '0;
         last_q   <= '0;
         mode_q   <= 1'b0;
         step_q   <= 1'b0;
         wrap_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         last_q   <= last_d;
         mode_q   <= mode_d;
         step_q   <= step_d;
         wrap_q   <= wrap_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      last_d   = last_q;
      mode_d   = mode_q;
      step_d   = 1'b0;
      wrap_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            sel_d = '0;
            if (start_i && !stop_i) begin
               state_d  = RUN;
               reload_d = reload_in;
               cnt_d    = reload_in;
               last_d   = sel_last_i;
               mode_d   = mode_cont_i;
            end
         end
         RUN: begin
            if (stop_i) begin
               state_d = IDLE;
               sel_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (sel_q < last_q) begin
               sel_d  = sel_q + SEL_W'(1);
               step_d = 1'b1;
               cnt_d  = reload_q;
            end else if (mode_q) begin
               sel_d  = '0;
               wrap_d = 1'b1;
               cnt_d  = reload_q;
            end else begin
               state_d = IDLE;
               sel_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   // Every output comes straight from a flop; no input-to-output paths.
   always_comb begin
      sel_o       = sel_q;
      sel_valid_o = (state_q == RUN);
      busy_o      = (state_q == RUN);
      step_o      = step_q;
      wrap_o      = wrap_q;
      done_o      = done_q;
   end

endmodule
